// File: rtl/mux_n_input_reg.sv
// rtl/mux_n_input_reg.sv - N-channel registered mux with valid/ready, external select or round-robin
// Optional Out_Par output (even parity of Out) when MUXN_PARITY_EN is defined.
module mux_n_input_reg #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int MODE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N*WIDTH-1:0]   In_Data,
  input  logic [N-1:0]         In_Valid,
  output logic [N-1:0]         In_Ready,
  input  logic [SEL_W-1:0]     S,
  output logic [WIDTH-1:0]     Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [SEL_W-1:0]     Out_Src
`ifdef MUXN_PARITY_EN
  ,
  output logic                 Out_Par
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef MUXN_PARITY_EN
  logic             out_par_q, out_par_d;
`endif

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  int               rr_idx;

  always_comb begin
    load_en   = !out_valid_q || Out_Ready;
    grant_vld = 1'b0;
    grant     = '0;
    rr_idx    = 0;
    In_Ready  = '0;
    xfer      = 1'b0;
    sel_data  = '0;

    if (MODE == 0) begin
      if (int'(S) < N) begin
        grant_vld = 1'b1;
        grant     = S;
      end
    end else begin
      // Scan from ptr upward with wrap; the first valid channel found wins.
      for (int k = 0; k < N; k++) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx >= N) rr_idx = rr_idx - N;
        if (!grant_vld && In_Valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(rr_idx);
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      In_Ready[i] = !RST && load_en && grant_vld && (int'(grant) == i);
      if (In_Ready[i] && In_Valid[i]) xfer = 1'b1;
      if (int'(grant) == i) sel_data = In_Data[i*WIDTH +: WIDTH];
    end

    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
`ifdef MUXN_PARITY_EN
    out_par_d   = out_par_q;
`endif

    if (xfer) begin
      out_d       = sel_data;
      out_valid_d = 1'b1;
      out_src_d   = grant;
      if (MODE == 1) ptr_d = (int'(grant) == N - 1) ? '0 : grant + SEL_W'(1);
`ifdef MUXN_PARITY_EN
      out_par_d   = ^sel_data;
`endif
    end else if (Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef MUXN_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
`ifdef MUXN_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign Out       = out_q;
  assign Out_Valid = out_valid_q;
  assign Out_Src   = out_src_q;
`ifdef MUXN_PARITY_EN
  assign Out_Par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_n_input_reg.sv
// tb/tb_mux_n_input_reg.sv - bench for mux_n_input_reg: select mode (N=4, N=3) and round-robin mode
// Exercises Out_Par as well when MUXN_PARITY_EN is defined.
module tb_mux_n_input_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  s;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [3:0] out0, out1, out2;
  logic       vld0, vld1, vld2;
  logic [1:0] src0, src1, src2;
`ifdef MUXN_PARITY_EN
  logic       par0, par1, par2;
`endif

  mux_n_input_reg #(.WIDTH(4), .N(4), .SEL_W(2), .MODE(0)) dut0 (
    .CLK(clk), .RST(rst), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(rdy0),
    .S(s), .Out(out0), .Out_Valid(vld0), .Out_Ready(out_ready), .Out_Src(src0)
`ifdef MUXN_PARITY_EN
    , .Out_Par(par0)
`endif
  );

  mux_n_input_reg #(.WIDTH(4), .N(4), .SEL_W(2), .MODE(1)) dut1 (
    .CLK(clk), .RST(rst), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(rdy1),
    .S(s), .Out(out1), .Out_Valid(vld1), .Out_Ready(out_ready), .Out_Src(src1)
`ifdef MUXN_PARITY_EN
    , .Out_Par(par1)
`endif
  );

  mux_n_input_reg #(.WIDTH(4), .N(3), .SEL_W(2), .MODE(0)) dut2 (
    .CLK(clk), .RST(rst), .In_Data(in_data[11:0]), .In_Valid(in_valid[2:0]), .In_Ready(rdy2),
    .S(s), .Out(out2), .Out_Valid(vld2), .Out_Ready(out_ready), .Out_Src(src2)
`ifdef MUXN_PARITY_EN
    , .Out_Par(par2)
`endif
  );

  logic [3:0] a_rdy [3];
  logic [3:0] a_out [3];
  logic       a_vld [3];
  logic [1:0] a_src [3];
  assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;  assign a_rdy[2] = {1'b0, rdy2};
  assign a_out[0] = out0;  assign a_out[1] = out1;  assign a_out[2] = out2;
  assign a_vld[0] = vld0;  assign a_vld[1] = vld1;  assign a_vld[2] = vld2;
  assign a_src[0] = src0;  assign a_src[1] = src1;  assign a_src[2] = src2;
`ifdef MUXN_PARITY_EN
  logic a_par [3];
  assign a_par[0] = par0;  assign a_par[1] = par1;  assign a_par[2] = par2;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural state of each instance
  int         m_mode [3] = '{0, 1, 0};
  int         m_n    [3] = '{4, 4, 3};
  logic [3:0] m_out  [3];
  bit         m_vld  [3];
  int         m_src  [3];
  int         m_ptr  [3];
  logic [3:0] x_out  [3];
  bit         x_vld  [3];
  int         x_src  [3];
  int         x_ptr  [3];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int mgrant(input int d);
    if (m_mode[d] == 0) return (int'(s) < m_n[d]) ? int'(s) : -1;
    for (int k = 0; k < m_n[d]; k++) begin
      int c;
      c = (m_ptr[d] + k) % m_n[d];
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mready(input int d);
    int g;
    g = mgrant(d);
    if (rst) return 4'h0;
    if ((!m_vld[d] || out_ready) && g >= 0) return 4'(1 << g);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_out[d] = 4'h0; m_vld[d] = 1'b0; m_src[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic step_pre();
    #1;
    for (int d = 0; d < 3; d++) begin
      int g;
      logic [3:0] r;
      g = mgrant(d);
      r = mready(d);
      chk("in_ready", d, 32'(a_rdy[d]), 32'(r));
      x_out[d] = m_out[d]; x_vld[d] = m_vld[d]; x_src[d] = m_src[d]; x_ptr[d] = m_ptr[d];
      if (rst) begin
        x_out[d] = 4'h0; x_vld[d] = 1'b0; x_src[d] = 0; x_ptr[d] = 0;
      end else if (r != 4'h0 && in_valid[g]) begin
        x_out[d] = 4'((in_data >> (g * 4)) & 16'hF);
        x_vld[d] = 1'b1;
        x_src[d] = g;
        x_ptr[d] = (g + 1) % m_n[d];
      end else if (out_ready) begin
        x_vld[d] = 1'b0;
      end
    end
  endtask

  task automatic step_post();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      m_out[d] = x_out[d]; m_vld[d] = x_vld[d]; m_src[d] = x_src[d]; m_ptr[d] = x_ptr[d];
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("out", d, 32'(a_out[d]), 32'(m_out[d]));
      chk("out_valid", d, 32'(a_vld[d]), 32'(m_vld[d]));
      chk("out_src", d, 32'(a_src[d]), 32'(m_src[d]));
`ifdef MUXN_PARITY_EN
      chk("out_par", d, 32'(a_par[d]), 32'(^m_out[d]));
`endif
    end
  endtask

  task automatic step();
    step_pre();
    step_post();
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] s;
    logic [3:0] v;
    logic [15:0] d;
    bit         ordy;
    logic [3:0] erdy;
    logic [3:0] eout;
    bit         evld;
    logic [1:0] esrc;
  } vec_t;

  vec_t tbl [10];

  int rr_src [6] = '{0, 1, 2, 3, 0, 1};
  int rr_out [6] = '{1, 2, 3, 4, 1, 2};

  initial begin
    // rst  s  valid    data      ordy  exp_rdy  out   vld  src
    tbl[0] = '{1, 2'd0, 4'b0000, 16'h0000, 1, 4'b0000, 4'h0, 0, 2'd0};
    tbl[1] = '{0, 2'd2, 4'b0100, 16'h0A00, 1, 4'b0100, 4'hA, 1, 2'd2};
    tbl[2] = '{0, 2'd1, 4'b0010, 16'h0030, 1, 4'b0010, 4'h3, 1, 2'd1};
    tbl[3] = '{0, 2'd3, 4'b1111, 16'h1234, 0, 4'b0000, 4'h3, 1, 2'd1};
    tbl[4] = '{0, 2'd0, 4'b1111, 16'h5678, 0, 4'b0000, 4'h3, 1, 2'd1};
    tbl[5] = '{0, 2'd2, 4'b0100, 16'h9ABC, 0, 4'b0000, 4'h3, 1, 2'd1};
    tbl[6] = '{0, 2'd0, 4'b0000, 16'h0000, 1, 4'b0001, 4'h3, 0, 2'd1};
    tbl[7] = '{0, 2'd3, 4'b1000, 16'hF000, 1, 4'b1000, 4'hF, 1, 2'd3};
    tbl[8] = '{0, 2'd3, 4'b0000, 16'h0000, 0, 4'b0000, 4'hF, 1, 2'd3};
    tbl[9] = '{1, 2'd1, 4'b1111, 16'hFFFF, 0, 4'b0000, 4'h0, 0, 2'd0};

    rst = 1'b1; s = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);

    // Select mode: load, stall, drain, mid-stream reset
    foreach (tbl[i]) begin
      rst = tbl[i].rst; s = tbl[i].s; in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      step_pre();
      chk("tbl_rdy", 0, 32'(rdy0), 32'(tbl[i].erdy));
      step_post();
      chk("tbl_out", 0, 32'(out0), 32'(tbl[i].eout));
      chk("tbl_vld", 0, 32'(vld0), 32'(tbl[i].evld));
      chk("tbl_src", 0, 32'(src0), 32'(tbl[i].esrc));
      @(negedge clk);
    end

    // Round-robin with all channels valid
    rst = 1'b1; step();
    rst = 1'b0; s = 2'd0; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_pre();
      step_post();
      chk("rr_src", 1, 32'(src1), 32'(rr_src[i]));
      chk("rr_out", 1, 32'(out1), 32'(rr_out[i]));
      chk("rr_vld", 1, 32'(vld1), 32'd1);
      @(negedge clk);
    end

    // Pointer wrap: move ptr to 3, then only ch0/ch1 requesting
    in_valid = 4'b0100; step();
    in_valid = 4'b0011;
    step_pre(); step_post();
    chk("wrap_src0", 1, 32'(src1), 32'd0);
    @(negedge clk);
    step_pre(); step_post();
    chk("wrap_src1", 1, 32'(src1), 32'd1);
    @(negedge clk);
    in_valid = 4'b1111;
    step_pre(); step_post();
    chk("ptr_after_wrap", 1, 32'(src1), 32'd2);
    @(negedge clk);

    // N=3: out-of-range select never grants, then mid-stream reset
    rst = 1'b1; step();
    rst = 1'b0; s = 2'd3; in_valid = 4'b1111; in_data = 16'h0765; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_pre();
      chk("oor_rdy", 2, 32'(rdy2), 32'd0);
      step_post();
      chk("oor_vld", 2, 32'(vld2), 32'd0);
      @(negedge clk);
    end
    s = 2'd0;
    step_pre(); step_post();
    chk("n3_load", 2, 32'(out2), 32'h5);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    step_pre(); step_post();
    chk("n3_rst_out", 2, 32'(out2), 32'h0);
    chk("n3_rst_vld", 2, 32'(vld2), 32'd0);
    @(negedge clk);

`ifdef MUXN_PARITY_EN
    rst = 1'b0; s = 2'd0; in_valid = 4'b0001; in_data = 16'h0007; out_ready = 1'b1;
    step_pre(); step_post();
    chk("par_0111", 0, 32'(par0), 32'd1);
    @(negedge clk);
    in_data = 16'h0005;
    step_pre(); step_post();
    chk("par_0101", 0, 32'(par0), 32'd0);
    @(negedge clk);
    in_data = 16'h0007; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_pre(); step_post();
      chk("par_hold", 0, 32'(par0), 32'd0);
      @(negedge clk);
    end
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      s         = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_n_input_reg.md
Name: mux_n_input_reg

Overview:
Parametrised successor to the 2-input 4-bit mux: N channels of WIDTH bits feed one output through a registered stage with valid/ready handshakes.
- Channel selection is either external (S port) or internal round-robin arbitration, chosen by the MODE parameter.
- Sits between multiple producer blocks and a single consumer.
- Provides one cycle of latency and full throughput of one word per cycle.

Parameters:
WIDTH, 4, data width per channel in bits (>=1)
N, 4, number of input channels (>=2)
SEL_W, 2, width of select/source index; must satisfy 2**SEL_W >= N
MODE, 0, 0 = external select via S; 1 = round-robin arbitration (S ignored)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
In_Data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
In_Valid  input  N  per-channel valid
In_Ready  output  N  per-channel ready (combinational)
S  input  SEL_W  channel select, used when MODE=0
Out  output  WIDTH  registered output data
Out_Valid  output  1  output word valid
Out_Ready  input  1  consumer ready
Out_Src  output  SEL_W  index of the channel that supplied Out

Behaviour:
- Reset (RST=1 at rising CLK):
  - Out=0, Out_Valid=0, Out_Src=0, round-robin pointer ptr=0.
  - Any held word is discarded.
  - In_Ready is all-zero while RST=1.
- load_en = !Out_Valid || Out_Ready. The output register may accept a new word only when load_en=1.
- Grant, combinational:
  - MODE=0: grant = S if S < N; else no grant. Out-of-range S stalls all inputs and never accepts data.
  - MODE=1: grant = first i with In_Valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N). No grant if no In_Valid is set.
- In_Ready[i] = load_en && grant exists && grant==i. At most one bit of In_Ready is set.
  - MODE=0: In_Ready[S] may be 1 while In_Valid[S]=0.
  - MODE=1: In_Ready only asserts on a valid channel.
- Transfer when In_Valid[g] && In_Ready[g]. On the next edge: Out<=channel g data, Out_Src<=g, Out_Valid<=1.
- No transfer and Out_Ready=1: Out_Valid<=0. Out and Out_Src hold their last values.
- No transfer and Out_Ready=0: all outputs hold.
- Stall rule: while Out_Valid=1 and Out_Ready=0, Out and Out_Src are stable and In_Ready is all-zero.
- Simultaneous drain and load (Out_Valid=1, Out_Ready=1, input transfer): the new word replaces the old one in the same edge, so Out_Valid stays 1. This sustains 1 word/cycle.
- Round-robin pointer (MODE=1): on each transfer from channel g, ptr<=(g+1) mod N. Without a transfer, ptr holds. Wrap: g=N-1 gives ptr=0.
- Changing S mid-stall has no effect on the held word; it only affects the next grant.
- Latency: input word appears on Out exactly 1 cycle after its transfer edge.

Optional Feature:
Macro MUXN_PARITY_EN.
- Defined:
  - Adds output port Out_Par (1 bit) = even parity (XOR reduction) of the word loaded into Out.
  - Registered together with Out; reset value 0; holds under stall.
- Not defined: port Out_Par does not exist; behaviour otherwise identical.

Test Plan:
1. Reset then MODE=0, N=4, WIDTH=4, S=2, In_Valid=4'b0100, channel2 data=4'hA, Out_Ready=1 -> In_Ready=4'b0100; next cycle Out=4'hA, Out_Src=2, Out_Valid=1.
2. MODE=0, Out holds 4'h3, Out_Ready=0 for 3 cycles while S and In_Data change -> Out=4'h3, Out_Valid=1, In_Ready=0 throughout. Out_Ready=1 with no input valid -> Out_Valid=0 next cycle.
3. MODE=1, all In_Valid=1, data ch0..3 = 1,2,3,4, Out_Ready=1 for 6 cycles -> Out_Src sequence 0,1,2,3,0,1; Out = 1,2,3,4,1,2; Out_Valid continuously 1.
4. MODE=1, ptr=3, In_Valid=4'b0011 -> grant channel 0 (wrap), then channel 1. Ptr after the two transfers = 2.
5. MODE=0, N=3, SEL_W=2, S=3 with all In_Valid=1 -> In_Ready=0, Out_Valid stays 0. Assert RST mid-stream with Out_Valid=1 -> next cycle Out=0, Out_Valid=0, Out_Src=0.
6. MUXN_PARITY_EN defined, load 4'b0111 then 4'b0101 -> Out_Par=1 then 0; holds under Out_Ready=0.
